fc_result_collector: RTL and testbench
======================================

# fc_result_collector

Post-processing stage directly downstream of the final fully-connected layer. On each completion of that layer it reads the two int8 class logits (female at 0x8000, male at 0x8001) back from feature RAM, cross-checks them against the layer's direct output ports, and makes the male/female decision with an unsigned margin. Each result is pushed into a small first-word-fall-through FIFO that the PS drains, and running per-class statistics are kept for batch evaluation.

## Interface
- RES_BASE, 16'h8000, RAM address of female logit; male logit at RES_BASE+1
- RAM_LAT, 2, RAM read latency in cycles (address/enable registered to data usable), legal 1..4
- FIFO_DEPTH, 4, result FIFO entries, power of two, 2..16
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fc_done  in  1  completion level from the FC stage (held high ≥1 cycle); rising edge triggers a collection
- female_in  in  8  signed female logit from the FC stage port
- male_in  in  8  signed male logit from the FC stage port
- ram_addr_r  out  16  RAM read address
- ram_en_r  out  1  RAM read enable
- ram_data_r  in  8  RAM read data (signed)
- res_valid  out  1  FIFO non-empty
- res_data  out  32  FIFO head (FWFT): [7:0] female, [15:8] male, [23:16] margin, [24] class (1=male), [25] mismatch, [31:26] 0; all zero when empty
- res_rd  in  1  pop head when res_valid
- fifo_level  out  5  entries held, 0..FIFO_DEPTH
- overflow  out  1  sticky: a result was dropped because FIFO full
- clr_stats  in  1  synchronous clear of counters and overflow
- img_cnt, male_cnt, female_cnt  out  16 each  saturating result counters
- busy  out  1  collection in progress
- done  out  1  one-cycle pulse when a result is pushed or dropped

## Operation
- Reset: all outputs 0; FIFO empty; FSM IDLE; edge register 0.
- Edge detect: fc_done_q registered each cycle; trigger = fc_done & ~fc_done_q. Trigger while busy is ignored; no queueing.
- FSM states: IDLE, READ, DECIDE, PUSH.
  - IDLE: on trigger → READ, rd counter c=0, busy=1.
  - READ: c increments each cycle. c=0: ram_addr_r=RES_BASE, ram_en_r=1. c=1: ram_addr_r=RES_BASE+1. ram_en_r deasserts at c=2; address holds. Female captured from ram_data_r at c=RAM_LAT, male at c=RAM_LAT+1; at the male capture → DECIDE.
  - DECIDE: class = (male > female) signed; tie → 0 (female). margin = |male − female|, computed 9-bit signed, result 0..255 in 8 bits. mismatch = (female ≠ female_in) | (male ≠ male_in), sampled this cycle. → PUSH.
  - PUSH: write entry if not full, else drop and set overflow; img_cnt+1, male_cnt or female_cnt +1 per class (saturate at 16'hFFFF; counted even if dropped). done=1, → IDLE, busy=0 on next cycle.
- FIFO: push and pop in same cycle when full → pop frees slot, push accepted, no overflow, level unchanged. res_rd while empty ignored. Pointers wrap modulo FIFO_DEPTH.
- clr_stats: counters and overflow → 0 next edge; takes precedence over a simultaneous PUSH increment/overflow set (that result's count lost, entry still written if room). FIFO not affected.
- Reset mid-collection: immediate return to IDLE, FIFO flushed, ram_en_r=0.

## Timing
- Trigger registered at edge T (fc_done high first sampled); READ begins T+1.
- Latency trigger → done pulse: RAM_LAT+4 cycles (6 at default); res_valid rises on the cycle after done.
- Back-to-back: next trigger accepted earliest the cycle after done.
- res_data/res_valid/fifo_level combinational from FIFO state; pop effective at the edge where res_rd=1.

## Test plan
- Single result: RAM 0x8000=−20, 0x8001=35, ports equal; pulse fc_done 3 cycles → done at cycle 6 after trigger, res_data=0x0137_23EC (class 1, margin 55, mismatch 0), male_cnt=1, img_cnt=1.
- Tie and extremes: female=male=−128 → class 0, margin 0; female=127, male=−128 → class 0, margin 255; female_cnt increments.
- Mismatch: RAM male=10, male_in=11 → bit 25 set, decision uses RAM value.
- Overflow: 5 collections, no res_rd → level 4, overflow=1, img_cnt=5, 5th entry absent; then res_rd on the cycle of 6th PUSH with FIFO full → accepted, overflow unchanged.
- Retrigger/hold: fc_done held high 20 cycles → exactly one collection; new rising edge during READ ignored.
- clr_stats coincident with PUSH → counters 0, entry in FIFO; async rst_n during READ → all outputs 0 immediately, res_valid=0.

Source files
------------

// File: rtl/fc_result_collector.sv
// Collects the two class logits from feature RAM after each FC completion, decides the class,
// and queues results in a FWFT FIFO while keeping saturating per-class statistics.
module fc_result_collector #(
    parameter logic [15:0] RES_BASE   = 16'h8000,
    parameter int unsigned RAM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_done,
    input  logic [7:0]  female_in,
    input  logic [7:0]  male_in,
    output logic [15:0] ram_addr_r,
    output logic        ram_en_r,
    input  logic [7:0]  ram_data_r,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_rd,
    output logic [4:0]  fifo_level,
    output logic        overflow,
    input  logic        clr_stats,
    output logic [15:0] img_cnt,
    output logic [15:0] male_cnt,
    output logic [15:0] female_cnt,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StDecide, StPush} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_fc_done_q;
    logic [2:0]    r_cnt;
    logic [15:0]   r_ram_addr;
    logic          r_ram_en;
    logic [7:0]    r_female, r_male;
    logic [25:0]   r_entry;
    logic [25:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_overflow;
    logic [15:0]   r_img_cnt, r_male_cnt, r_female_cnt;

    logic          w_trigger;
    logic          w_female_cap, w_male_cap;
    logic signed [8:0] w_diff;
    logic [8:0]    w_abs;
    logic          w_class, w_mismatch;
    logic          w_full, w_empty, w_pop, w_push, w_push_st;

    assign w_trigger    = fc_done & ~r_fc_done_q;
    assign w_female_cap = (r_state == StRead) && (r_cnt == 3'(RAM_LAT));
    assign w_male_cap   = (r_state == StRead) && (r_cnt == 3'(RAM_LAT + 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (w_trigger) w_state_nxt = StRead;
            StRead:   if (w_male_cap) w_state_nxt = StDecide;
            StDecide: w_state_nxt = StPush;
            StPush:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Sign-extend to 9 bits so |male - female| spans the full 0..255 range.
    assign w_diff     = $signed({r_male[7], r_male}) - $signed({r_female[7], r_female});
    assign w_abs      = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
    assign w_class    = $signed(r_male) > $signed(r_female);
    assign w_mismatch = (r_female != female_in) || (r_male != male_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_fc_done_q <= 1'b0;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_en    <= 1'b0;
            r_female    <= '0;
            r_male      <= '0;
            r_entry     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fc_done_q <= fc_done;
            if (r_state == StIdle && w_trigger) begin
                r_cnt      <= '0;
                r_ram_addr <= RES_BASE;
                r_ram_en   <= 1'b1;
            end else if (r_state == StRead) begin
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd0) r_ram_addr <= RES_BASE + 16'd1;
                if (r_cnt == 3'd1) r_ram_en <= 1'b0;
            end
            if (w_female_cap) r_female <= ram_data_r;
            if (w_male_cap)   r_male   <= ram_data_r;
            if (r_state == StDecide) begin
                r_entry <= {w_mismatch, w_class, w_abs[7:0], r_male, r_female};
            end
        end
    end

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == 5'(FIFO_DEPTH));
    assign w_pop     = res_rd && !w_empty;
    assign w_push_st = (r_state == StPush);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_push_st && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + 5'(w_push) - 5'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_img_cnt    <= '0;
            r_male_cnt   <= '0;
            r_female_cnt <= '0;
        end else if (clr_stats) begin
            r_overflow   <= 1'b0;
            r_img_cnt    <= '0;
            r_male_cnt   <= '0;
            r_female_cnt <= '0;
        end else if (w_push_st) begin
            if (!w_push) r_overflow <= 1'b1;
            if (r_img_cnt != 16'hFFFF) r_img_cnt <= r_img_cnt + 16'd1;
            if (r_entry[24]) begin
                if (r_male_cnt != 16'hFFFF) r_male_cnt <= r_male_cnt + 16'd1;
            end else begin
                if (r_female_cnt != 16'hFFFF) r_female_cnt <= r_female_cnt + 16'd1;
            end
        end
    end

    assign ram_addr_r = r_ram_addr;
    assign ram_en_r   = r_ram_en;
    assign res_valid  = !w_empty;
    assign res_data   = w_empty ? 32'd0 : {6'd0, r_mem[r_rd_ptr]};
    assign fifo_level = r_count;
    assign overflow   = r_overflow;
    assign img_cnt    = r_img_cnt;
    assign male_cnt   = r_male_cnt;
    assign female_cnt = r_female_cnt;
    assign busy       = (r_state != StIdle);
    assign done       = w_push_st;

endmodule

// File: tb/tb_fc_result_collector.sv
// Directed bench for fc_result_collector: table of single collections plus hand-written
// sequences for retrigger, hold, clear, overflow and asynchronous reset.
module tb_fc_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fc_done, res_rd, clr_stats;
    logic [7:0]  female_in, male_in, ram_data_r;
    logic [15:0] ram_addr_r, img_cnt, male_cnt, female_cnt;
    logic        ram_en_r, res_valid, overflow, busy, done;
    logic [31:0] res_data;
    logic [4:0]  fifo_level;

    logic [7:0]  ram_f, ram_m;
    logic [15:0] pipe0, pipe1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  f_ram;
        logic [7:0]  m_ram;
        logic [7:0]  f_in;
        logic [7:0]  m_in;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    fc_result_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fc_done    (fc_done),
        .female_in  (female_in),
        .male_in    (male_in),
        .ram_addr_r (ram_addr_r),
        .ram_en_r   (ram_en_r),
        .ram_data_r (ram_data_r),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_stats  (clr_stats),
        .img_cnt    (img_cnt),
        .male_cnt   (male_cnt),
        .female_cnt (female_cnt),
        .busy       (busy),
        .done       (done)
    );

    // Two-cycle read latency RAM holding only the two logit locations.
    always @(posedge clk) begin
        pipe0 <= ram_en_r ? ram_addr_r : 16'h0000;
        pipe1 <= pipe0;
    end
    assign ram_data_r = (pipe1 == 16'h8000) ? ram_f :
                        (pipe1 == 16'h8001) ? ram_m : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; runs a fixed 25-cycle window after raising fc_done.
    task automatic collect(input logic [7:0] f_ram, input logic [7:0] m_ram,
                           input logic [7:0] f_in, input logic [7:0] m_in,
                           input int hold, input int retrig_at,
                           input bit pop_on_done, input bit clr_on_done,
                           output int lat, output int ndone,
                           output logic v_at, output logic v_after);
        ram_f = f_ram; ram_m = m_ram; female_in = f_in; male_in = m_in;
        fc_done = 1'b1;
        lat = -1; ndone = 0; v_at = 1'bx; v_after = 1'bx;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            @(negedge clk);
            res_rd = 1'b0;
            clr_stats = 1'b0;
            if (k == hold) fc_done = 1'b0;
            if (retrig_at != 0 && k == retrig_at) fc_done = 1'b1;
            if (retrig_at != 0 && k == retrig_at + 1) fc_done = 1'b0;
            if (lat >= 0 && k == lat + 1) v_after = res_valid;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = k;
                    v_at = res_valid;
                    if (pop_on_done) res_rd = 1'b1;
                    if (clr_on_done) clr_stats = 1'b1;
                end
            end
        end
        fc_done = 1'b0;
    endtask

    task automatic pop();
        res_rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_rd = 1'b0;
    endtask

    int   lat, nd;
    logic va, vn;
    int   m_img, m_male, m_fem;

    initial begin
        vecs[0] = '{8'hEC, 8'h23, 8'hEC, 8'h23, 32'h013723EC}; // -20 vs 35
        vecs[1] = '{8'h80, 8'h80, 8'h80, 8'h80, 32'h00008080}; // tie at -128
        vecs[2] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 32'h00FF807F}; // 127 vs -128
        vecs[3] = '{8'h05, 8'h0A, 8'h05, 8'h0B, 32'h03050A05}; // male port disagrees
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h010100FF}; // -1 vs 0

        rst_n = 1'b0; fc_done = 1'b0; res_rd = 1'b0; clr_stats = 1'b0;
        female_in = '0; male_in = '0; ram_f = '0; ram_m = '0;
        pipe0 = '0; pipe1 = '0;
        m_img = 0; m_male = 0; m_fem = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_en", {31'd0, ram_en_r}, 32'd0);
        chk("rst_addr", {16'd0, ram_addr_r}, 32'd0);
        chk("rst_img", {16'd0, img_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            collect(vecs[i].f_ram, vecs[i].m_ram, vecs[i].f_in, vecs[i].m_in, 3, 0, 1'b0, 1'b0,
                    lat, nd, va, vn);
            m_img++;
            if (vecs[i].exp[24]) m_male++; else m_fem++;
            chk($sformatf("v%0d_latency", i), lat, 6);
            chk($sformatf("v%0d_ndone", i), nd, 1);
            chk($sformatf("v%0d_valid_at_done", i), {31'd0, va}, 32'd0);
            chk($sformatf("v%0d_valid_after", i), {31'd0, vn}, 32'd1);
            chk($sformatf("v%0d_data", i), res_data, vecs[i].exp);
            chk($sformatf("v%0d_level", i), {27'd0, fifo_level}, 32'd1);
            chk($sformatf("v%0d_img", i), {16'd0, img_cnt}, m_img);
            chk($sformatf("v%0d_male", i), {16'd0, male_cnt}, m_male);
            chk($sformatf("v%0d_female", i), {16'd0, female_cnt}, m_fem);
            pop();
            chk($sformatf("v%0d_level_pop", i), {27'd0, fifo_level}, 32'd0);
            chk($sformatf("v%0d_data_empty", i), res_data, 32'd0);
        end

        // New rising edge during READ must be ignored.
        collect(8'hEC, 8'h23, 8'hEC, 8'h23, 1, 2, 1'b0, 1'b0, lat, nd, va, vn);
        chk("retrig_ndone", nd, 1);
        chk("retrig_level", {27'd0, fifo_level}, 32'd1);
        chk("retrig_img", {16'd0, img_cnt}, 32'd6);
        pop();

        // fc_done held high for many cycles gives one collection.
        collect(8'hEC, 8'h23, 8'hEC, 8'h23, 20, 0, 1'b0, 1'b0, lat, nd, va, vn);
        chk("hold_ndone", nd, 1);
        chk("hold_latency", lat, 6);
        chk("hold_level", {27'd0, fifo_level}, 32'd1);
        chk("hold_img", {16'd0, img_cnt}, 32'd7);
        pop();

        // clr_stats coincident with PUSH wins over the increment, entry still written.
        collect(8'hEC, 8'h23, 8'hEC, 8'h23, 3, 0, 1'b0, 1'b1, lat, nd, va, vn);
        chk("clr_img", {16'd0, img_cnt}, 32'd0);
        chk("clr_male", {16'd0, male_cnt}, 32'd0);
        chk("clr_level", {27'd0, fifo_level}, 32'd1);
        chk("clr_data", res_data, 32'h013723EC);
        pop();

        // Overflow: five results into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            collect(8'(i), 8'h00, 8'(i), 8'h00, 3, 0, 1'b0, 1'b0, lat, nd, va, vn);
        end
        chk("ovf_level", {27'd0, fifo_level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_img", {16'd0, img_cnt}, 32'd5);
        chk("ovf_female", {16'd0, female_cnt}, 32'd5);
        chk("ovf_head", res_data, 32'h00010001);
        // Sixth result with a pop on the PUSH cycle while full.
        collect(8'h06, 8'h00, 8'h06, 8'h00, 3, 0, 1'b1, 1'b0, lat, nd, va, vn);
        chk("full_pop_level", {27'd0, fifo_level}, 32'd4);
        chk("full_pop_flag", {31'd0, overflow}, 32'd1);
        chk("full_pop_img", {16'd0, img_cnt}, 32'd6);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (i < 3) ? ((32'(i + 2) << 16) | 32'(i + 2)) : 32'h00060006;
            chk($sformatf("drain%0d", i), res_data, e);
            pop();
        end
        chk("drain_valid", {31'd0, res_valid}, 32'd0);
        res_rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_rd = 1'b0;
        chk("rd_empty_level", {27'd0, fifo_level}, 32'd0);

        clr_stats = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_stats = 1'b0;
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        chk("clr_female", {16'd0, female_cnt}, 32'd0);

        // Asynchronous reset in the middle of READ.
        collect(8'hEC, 8'h23, 8'hEC, 8'h23, 3, 0, 1'b0, 1'b0, lat, nd, va, vn);
        chk("pre_rst_level", {27'd0, fifo_level}, 32'd1);
        fc_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fc_done = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_en", {31'd0, ram_en_r}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_en", {31'd0, ram_en_r}, 32'd0);
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_level", {27'd0, fifo_level}, 32'd0);
        chk("arst_img", {16'd0, img_cnt}, 32'd0);
        chk("arst_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
